store_wbuf: RTL and testbench
=============================

Name: store_wbuf

Overview:
- Parametrised store path for the MEM stage.
- Takes store requests (address, data, size), checks alignment, and generates the byte-lane write strobe with lane-replicated write data.
- Queues accepted stores in a DEPTH-entry write buffer, then drains them to data RAM over a valid/ready handshake.
- Replaces the per-cycle combinational write-enable decode. Supports 32- and 64-bit data paths and raises a registered address-error indication.

Parameters:
- DATA_W, 32, data path width; legal values 32 or 64.
- ADDR_W, 32, byte address width.
- DEPTH, 4, write buffer entries; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  buffer can accept (= not full).
- req_kill  in  1  exception in flight; request must not be written.
- req_addr  in  ADDR_W  store byte address.
- req_data  in  DATA_W  store data, right-justified.
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword (legal only when DATA_W=64).
- ades  out  1  one-cycle pulse: misaligned or illegal-size store.
- ades_badvaddr  out  ADDR_W  faulting address, held until the next ades.
- mem_valid  out  1  head entry valid.
- mem_ready  in  1  data RAM accepts head.
- mem_addr  out  ADDR_W  address aligned to DATA_W/8.
- mem_wdata  out  DATA_W  lane-replicated data.
- mem_wstrb  out  DATA_W/8  byte strobes.
- count  out  clog2(DEPTH)+1  occupied entries.
- empty  out  1  count==0.

Behaviour:
- Reset values: all outputs 0 except req_ready=1 and empty=1; ades_badvaddr=0. FIFO pointers are cleared.
- Reset asserted mid-drain discards all entries. No partial write may be left presented.
- Accept is req_valid & req_ready.
- An accepted request with req_kill=1 is consumed and dropped: no enqueue, no ades.
- Byte offset off = req_addr[clog2(DATA_W/8)-1:0].
- Strobe rules:
  - byte: strobe = 1<<off.
  - half: strobe = 2'b11<<off; off[0] must be 0.
  - word: strobe = 4'hF<<off; off[1:0] must be 0.
  - dword: all ones; off must be 0.
- Misaligned, or size 3 when DATA_W=32:
  - no enqueue;
  - ades pulses 1 the cycle after accept;
  - ades_badvaddr is loaded with req_addr on that same edge.
- Write data: low 8/16/32 bits of req_data replicated across all lanes of DATA_W.
- Enqueue takes effect at the clock edge. The entry is visible on mem_* the following cycle, so enqueue-to-mem_valid latency is 1.
- Head is popped on mem_valid & mem_ready. mem_* outputs come straight from the registered head entry, with no combinational path from req_*.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- When full, req_ready=0 even if mem_ready=1 this cycle; there is no full-bypass.
- Pointers wrap modulo DEPTH. An extra wrap bit distinguishes full from empty.
- Stores drain strictly in program order.
- ades and enqueue are mutually exclusive for any single request.

Optional Feature:
- Macro: STORE_MERGE_EN.
- With the macro defined:
  - An aligned, non-killed request merges into the tail entry instead of allocating when all of these hold:
    - the FIFO is non-empty;
    - its mem_addr equals the tail entry's aligned address;
    - the tail is not also the head being popped this cycle.
  - On merge, the tail's strobe becomes old|new, and the new bytes overwrite the selected lanes.
  - count is unchanged; req_ready stays 1 even when full if merge is possible.
- Without the macro: every accepted aligned store allocates its own entry.

Decomposition:
- Shared package store_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - entry struct {addr, data, strb};
  - a clog2 helper function.
- One combinational sub-module, wstrb_gen: (addr offset, size) -> strobe, replicated data, misalign flag. It is reused by the load-side extension logic.

Test Plan:
- Reset, then byte store to 0x1003, data 0xAB, DATA_W=32 -> next cycle mem_valid=1, mem_addr=0x1000, mem_wstrb=4'b1000, mem_wdata=0xABABABAB.
- Half store to 0x2001 -> no enqueue; ades=1 for exactly one cycle; ades_badvaddr=0x2001; count stays 0.
- mem_ready=0 while 4 words are pushed (DEPTH=4) -> count=4, req_ready=0. Then mem_ready=1 -> drain order matches push order, 1 entry per cycle, empty=1 after the 4th pop.
- Push with req_kill=1, word to 0x3000 -> no mem_valid, no ades, count=0.
- Simultaneous push/pop at count=2 -> count remains 2. Pointer wrap is exercised over 10 pushes.
- STORE_MERGE_EN: byte to 0x4000 then byte to 0x4002 with mem_ready=0 -> count=1, mem_wstrb=4'b0101. With the macro undefined the same stimulus gives count=2.

Source files
------------

// File: rtl/store_pkg.sv
// store_pkg: store-path size encodings and width helper shared by the store buffer and load-side logic
package store_pkg;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} size_e;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/wstrb_gen.sv
// wstrb_gen: byte-lane strobe, lane-replicated data and misalign flag for one access
module wstrb_gen
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB = DATA_W / 8,
    localparam int OFF_W = clog2(NB)
) (
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] data,
    output logic [NB-1:0]     strb,
    output logic [DATA_W-1:0] wdata,
    output logic              misalign
);
    assign strb = size == SZ_BYTE ? NB'(1) << off
                : size == SZ_HALF ? NB'(3) << off
                : size == SZ_WORD ? NB'(15) << off : {NB{1'b1}};
    assign wdata = size == SZ_BYTE ? {NB{data[7:0]}}
                 : size == SZ_HALF ? {NB/2{data[15:0]}}
                 : size == SZ_WORD ? {DATA_W/32{data[31:0]}} : data;
    // a dword access has no legal lane placement on a 32-bit path
    assign misalign = size == SZ_HALF ? off[0]
                    : size == SZ_WORD ? |off[1:0]
                    : size == SZ_DWORD ? (DATA_W == 32) || |off : 1'b0;
endmodule

// File: rtl/store_wbuf.sv
// store_wbuf: aligned store queue draining to data RAM over valid/ready.
// Define STORE_MERGE_EN to merge stores to the tail's aligned address instead of allocating.
module store_wbuf
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH = 4,
    localparam int NB = DATA_W / 8,
    localparam int OFF_W = clog2(NB),
    localparam int PW = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_kill,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_size,
    output logic              ades,
    output logic [ADDR_W-1:0] ades_badvaddr,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [NB-1:0]     mem_wstrb,
    output logic [PW:0]       count,
    output logic              empty
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [NB-1:0]     strb;
    } entry_t;

    entry_t            q [DEPTH];
    entry_t            head;
    logic [PW:0]       wp, rp;
    logic [ADDR_W-1:0] al_addr;
    logic [NB-1:0]     g_strb;
    logic [DATA_W-1:0] g_wdata;
    logic              mis, full, acc, pop, push, merge_ok, ades_nx;

    wstrb_gen #(.DATA_W(DATA_W)) u_gen (
        .off(req_addr[OFF_W-1:0]),
        .size(req_size),
        .data(req_data),
        .strb(g_strb),
        .wdata(g_wdata),
        .misalign(mis)
    );

    assign al_addr = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign head = q[rp[PW-1:0]];
    assign count = wp - rp;
    assign empty = wp == rp;
    assign full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    // stale slots are never presented: outputs read zero while nothing is queued
    assign mem_valid = !empty;
    assign mem_addr = mem_valid ? head.addr : '0;
    assign mem_wdata = mem_valid ? head.data : '0;
    assign mem_wstrb = mem_valid ? head.strb : '0;
    assign pop = mem_valid & mem_ready;
    assign req_ready = !full || merge_ok;
    assign acc = req_valid & req_ready;
    assign ades_nx = acc & !req_kill & mis;
    assign push = acc & !req_kill & !mis & !merge_ok;

`ifdef STORE_MERGE_EN
    logic [PW-1:0]     tail_idx;
    entry_t            tail;
    logic [DATA_W-1:0] m_data;

    assign tail_idx = wp[PW-1:0] - 1'b1;
    assign tail = q[tail_idx];
    // a single-entry queue being drained this cycle cannot absorb new bytes
    assign merge_ok = !empty && tail.addr == al_addr && !(pop && tail_idx == rp[PW-1:0]) && !mis && !req_kill;

    always_comb begin
        m_data = tail.data;
        for (int i = 0; i < NB; i++)
            if (g_strb[i]) m_data[8*i +: 8] = g_wdata[8*i +: 8];
    end
`else
    assign merge_ok = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            wp <= '0;
            rp <= '0;
            ades <= 1'b0;
            ades_badvaddr <= '0;
        end else begin
            ades <= ades_nx;
            if (ades_nx) ades_badvaddr <= req_addr;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end

    always_ff @(posedge clk) begin
        if (push) q[wp[PW-1:0]] <= '{addr: al_addr, data: g_wdata, strb: g_strb};
`ifdef STORE_MERGE_EN
        if (acc && merge_ok) q[tail_idx] <= '{addr: tail.addr, data: m_data, strb: tail.strb | g_strb};
`endif
    end
endmodule

// File: tb/tb_store_wbuf.sv
// tb_store_wbuf: directed checks of store_wbuf (DATA_W=32, DEPTH=4); honours STORE_MERGE_EN
module tb_store_wbuf;
    import store_pkg::*;

`ifdef STORE_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_kill;
    logic [31:0] req_addr, req_data;
    logic [1:0]  req_size;
    logic        ades;
    logic [31:0] ades_badvaddr;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [2:0]  count;
    logic        empty;

    int checks = 0;
    int errors = 0;

    store_wbuf #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_kill(req_kill),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .ades(ades), .ades_badvaddr(ades_badvaddr),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        kill;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        e_ades;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
    } vec_t;

    vec_t vt [11];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic k, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = v;
        req_kill = k;
        req_addr = a;
        req_data = d;
        req_size = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] bad;
        vt[0]  = '{1'b0, 32'h1003, 32'h000000AB, SZ_BYTE,  1'b0, 1'b1, 32'h1000, 32'hABABABAB, 4'b1000};
        vt[1]  = '{1'b0, 32'h2001, 32'h00001234, SZ_HALF,  1'b1, 1'b0, 32'h0,    32'h0,        4'b0000};
        vt[2]  = '{1'b0, 32'h2002, 32'h1234BEEF, SZ_HALF,  1'b0, 1'b1, 32'h2000, 32'hBEEFBEEF, 4'b1100};
        vt[3]  = '{1'b1, 32'h3000, 32'h5555AAAA, SZ_WORD,  1'b0, 1'b0, 32'h0,    32'h0,        4'b0000};
        vt[4]  = '{1'b0, 32'h3004, 32'hDEADBEEF, SZ_WORD,  1'b0, 1'b1, 32'h3004, 32'hDEADBEEF, 4'b1111};
        vt[5]  = '{1'b0, 32'h3006, 32'h00000000, SZ_WORD,  1'b1, 1'b0, 32'h0,    32'h0,        4'b0000};
        vt[6]  = '{1'b0, 32'h4000, 32'h00000001, SZ_DWORD, 1'b1, 1'b0, 32'h0,    32'h0,        4'b0000};
        vt[7]  = '{1'b0, 32'h5000, 32'h0000007E, SZ_BYTE,  1'b0, 1'b1, 32'h5000, 32'h7E7E7E7E, 4'b0001};
        vt[8]  = '{1'b0, 32'h5000, 32'h0000CAFE, SZ_HALF,  1'b0, 1'b1, 32'h5000, 32'hCAFECAFE, 4'b0011};
        vt[9]  = '{1'b0, 32'h5001, 32'h00000011, SZ_BYTE,  1'b0, 1'b1, 32'h5000, 32'h11111111, 4'b0010};
        vt[10] = '{1'b1, 32'h2001, 32'h00000000, SZ_HALF,  1'b0, 1'b0, 32'h0,    32'h0,        4'b0000};

        resetn = 1'b0;
        mem_ready = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ades", ades, 0);
        chk("rst_badvaddr", ades_badvaddr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        resetn = 1'b1;
        tick;

        // one request at a time, drained immediately
        bad = 32'h0;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vt[i].kill, vt[i].addr, vt[i].data, vt[i].size);
            tick;
            drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
            if (vt[i].e_ades) bad = vt[i].addr;
            @(negedge clk);
            chk($sformatf("v%0d_ades", i), ades, vt[i].e_ades);
            chk($sformatf("v%0d_badvaddr", i), ades_badvaddr, bad);
            chk($sformatf("v%0d_mem_valid", i), mem_valid, vt[i].e_valid);
            chk($sformatf("v%0d_count", i), count, vt[i].e_valid);
            if (vt[i].e_valid) begin
                chk($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].e_addr);
                chk($sformatf("v%0d_mem_wstrb", i), mem_wstrb, vt[i].e_strb);
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vt[i].e_wdata);
            end
            tick;
            @(negedge clk);
            chk($sformatf("v%0d_ades_drop", i), ades, 0);
            chk($sformatf("v%0d_empty", i), empty, 1);
            tick;
        end

        // fill to DEPTH with the RAM stalled, then drain in order
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k), SZ_WORD);
            tick;
        end
        drive(1'b1, 1'b0, 32'h110, 32'h55, SZ_WORD);
        @(negedge clk);
        chk("full_count", count, 4);
        chk("full_req_ready", req_ready, 0);
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        @(negedge clk);
        chk("full_hold_count", count, 4);
        mem_ready = 1'b1;
        #1;
        chk("full_no_bypass", req_ready, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_valid", k), mem_valid, 1);
            chk($sformatf("drain%0d_addr", k), mem_addr, 32'h100 + 32'(4 * k));
            chk($sformatf("drain%0d_wdata", k), mem_wdata, 32'hA0 + 32'(k));
            @(posedge clk);
            @(negedge clk);
        end
        chk("drain_empty", empty, 1);
        tick;

        // steady push+pop at count 2 across pointer wrap
        mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 32'h600 + 32'(4 * k), 32'(k), SZ_WORD);
            tick;
        end
        mem_ready = 1'b1;
        for (int k = 2; k < 10; k++) begin
            drive(1'b1, 1'b0, 32'h600 + 32'(4 * k), 32'(k), SZ_WORD);
            @(negedge clk);
            chk($sformatf("wrap%0d_count", k), count, 2);
            chk($sformatf("wrap%0d_addr", k), mem_addr, 32'h600 + 32'(4 * (k - 2)));
            tick;
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        for (int k = 8; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("wrap%0d_tail_addr", k), mem_addr, 32'h600 + 32'(4 * k));
            tick;
        end
        @(negedge clk);
        chk("wrap_empty", empty, 1);
        tick;

        // two bytes to the same word with the RAM stalled
        mem_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h4000, 32'h11, SZ_BYTE);
        tick;
        drive(1'b1, 1'b0, 32'h4002, 32'h22, SZ_BYTE);
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        @(negedge clk);
        chk("merge_count", count, MERGE ? 3'd1 : 3'd2);
        chk("merge_addr", mem_addr, 32'h4000);
        chk("merge_wstrb", mem_wstrb, MERGE ? 4'b0101 : 4'b0001);
        chk("merge_wdata", mem_wdata, MERGE ? 32'h11221111 : 32'h11111111);
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("merge_drained", empty, 1);
        tick;

        // reset while entries are queued and being presented
        mem_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h700, 32'h1, SZ_WORD);
        tick;
        drive(1'b1, 1'b0, 32'h704, 32'h2, SZ_WORD);
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        @(negedge clk);
        chk("pre_rst_count", count, 2);
        mem_ready = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("midrst_valid", mem_valid, 0);
        chk("midrst_count", count, 0);
        chk("midrst_wstrb", mem_wstrb, 0);
        chk("midrst_req_ready", req_ready, 1);
        tick;
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_empty", empty, 1);
        chk("post_rst_valid", mem_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
